// File: rtl/buffer_share_arbiter_if.sv
// Handshake bundle between N requesters, the shared output buffer and its consumer.
interface buffer_share_arbiter_if #(
  parameter int K   = 16,
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [N*K-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [K-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] grant_id;
  logic           busy;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_data, out_valid, grant_id, busy
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_data, out_valid, grant_id, busy
  );
endinterface

// File: rtl/buffer_share_arbiter.sv
// Round-robin arbiter loading one of N requester words into a single shared K-bit buffer
// register; the buffer can drain and refill on the same edge, giving one transfer per cycle.
module buffer_share_arbiter #(
  parameter int K   = 16,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  buffer_share_arbiter_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [K-1:0]   r_out_data;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] r_last;

  logic           w_can_accept;
  logic           w_found;
  logic [IDW-1:0] w_win;
  logic           w_take;
  logic [N-1:0]   w_req_ready;

  // Search starts just after the last winner so every requester gets a turn within N grants.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int off = 1; off <= N; off++) begin
      if (!w_found && bus.req_valid[(int'(r_last) + off) % N]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_last) + off) % N);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = '0;
    w_can_accept = (r_state == EMPTY) || bus.out_ready;
    w_take       = w_can_accept && w_found;
    if (w_take) begin
      w_req_ready[w_win] = 1'b1;
      w_state_nxt        = FULL;
    end else if (r_state == FULL && bus.out_ready) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_out_data <= '0;
      r_grant_id <= '0;
      r_last     <= IDW'(N - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_out_data <= bus.req_data[K*w_win +: K];
        r_grant_id <= w_win;
        r_last     <= w_win;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = (r_state == FULL);
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = (r_state == FULL);

endmodule

// File: tb/tb_buffer_share_arbiter.sv
// Directed bench for buffer_share_arbiter: accepted words are queued and checked when they reach the buffer.
module tb_buffer_share_arbiter;

  logic clk;
  logic rst;

  buffer_share_arbiter_if #(.K(16), .N(4), .IDW(2)) bus ();

  buffer_share_arbiter #(.K(16), .N(4), .IDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  id;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_data;
  logic [1:0]  exp_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check combinational grant, then the buffer after the edge.
  task automatic step(input logic r, input logic [3:0] vld, input logic ordy,
                      input logic [3:0] exp_rr, input logic exp_ov);
    exp_t e;
    rst           = r;
    bus.req_valid = vld;
    bus.out_ready = ordy;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rr));
    for (int i = 0; i < 4; i++) begin
      if (exp_rr == 4'(1 << i)) begin
        e.data = bus.req_data[16*i +: 16];
        e.id   = 2'(i);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_data = 16'h0000;
      exp_id   = 2'd0;
    end else if (sb.size() > 0) begin
      e        = sb.pop_front();
      exp_data = e.data;
      exp_id   = e.id;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    chk("busy",      32'(bus.busy),      32'(exp_ov));
    chk("out_data",  32'(bus.out_data),  32'(exp_data));
    chk("grant_id",  32'(bus.grant_id),  32'(exp_id));
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    bus.req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    exp_data      = 16'h0000;
    exp_id        = 2'd0;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0000);
    chk("rst_grant_id",  32'(bus.grant_id),  32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // First grant goes to requester 0
    step(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1);

    // Round robin, no bubbles
    step(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1);

    // Load 0x2222, then backpressure for three cycles
    step(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1);
    chk("bp_load", 32'(bus.out_data), 32'h2222);
    step(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1);
    chk("bp_hold", 32'(bus.out_data), 32'h2222);
    step(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1);

    // Drain to empty; out_ready ignored while empty
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
    chk("drain_hold", 32'(bus.out_data), 32'h3333);
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    bus.req_data[32 +: 16] = 16'hBEEF;
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
    chk("beef_data", 32'(bus.out_data), 32'h0000BEEF);
    chk("beef_id",   32'(bus.grant_id), 32'd2);
    bus.req_data[32 +: 16] = 16'h3333;

    // Mid-transfer reset while full and stalled
    step(1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1);
    step(1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1);

    // Sparse requesters with last=3
    step(1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1);
    step(1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1);
    step(1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1);
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
